// File: rtl/hazard_pkg.sv
// Shared definitions for the register hazard scoreboard.
//
// Contents:
//   MAX_LAT_DEF - default largest fixed result latency, in cycles.
//   LAT_W       - width of a latency value and of an entry's down-counter.
//   sb_entry_t  - one register's tracking state: pending, ext, cnt.
//
// Every counter in the design is LAT_W wide. A MAX_LAT other than the default
// must therefore satisfy $clog2(MAX_LAT + 1) <= LAT_W.
package hazard_pkg;

    localparam int unsigned MAX_LAT_DEF = 4;
    localparam int unsigned LAT_W       = $clog2(MAX_LAT_DEF + 1);

    typedef struct packed {
        logic             pending;  // result not yet forwardable
        logic             ext;      // waiting for an external completion, cnt unused
        logic [LAT_W-1:0] cnt;      // cycles left until forwardable (fixed latency)
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage <-> scoreboard interface.
//
// master: the ID stage. It drives the instruction fields, flush and the
//         external completions, and receives stall, issue and busy_vec.
// slave : the scoreboard.
//
// Signals:
//   id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used  - source operands
//   id_rd, id_regwrite, id_lat                          - destination; id_lat 0 = unknown
//   flush                                               - squash the ID instruction
//   ext_done_valid, ext_done_rd                         - unknown-latency result ready
//   id_stall, id_issue, busy_vec                        - scoreboard responses
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned MAX_LAT  = MAX_LAT_DEF
);

    localparam int unsigned IdxW = $clog2(NUM_REGS);
    localparam int unsigned LatW = $clog2(MAX_LAT + 1);

    logic                id_valid;
    logic [IdxW-1:0]     id_rs1;
    logic [IdxW-1:0]     id_rs2;
    logic                id_rs1_used;
    logic                id_rs2_used;
    logic [IdxW-1:0]     id_rd;
    logic                id_regwrite;
    logic [LatW-1:0]     id_lat;
    logic                flush;
    logic                ext_done_valid;
    logic [IdxW-1:0]     ext_done_rd;
    logic                id_stall;
    logic                id_issue;
    logic [NUM_REGS-1:0] busy_vec;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output id_rd, id_regwrite, id_lat, flush, ext_done_valid, ext_done_rd,
        input  id_stall, id_issue, busy_vec
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  id_rd, id_regwrite, id_lat, flush, ext_done_valid, ext_done_rd,
        output id_stall, id_issue, busy_vec
    );

endinterface

// File: rtl/sb_entry.sv
// One register's scoreboard entry.
//
// Ports:
//   clk_i, rst_ni  - clock; asynchronous active-low reset clears the entry
//   load_i         - an instruction writing this register issues this cycle
//   load_ext_i     - that instruction has unknown latency
//   load_cnt_i     - its fixed latency, ignored when load_ext_i is set
//   ext_clr_i      - external completion addressed to this register
//   entry_o        - registered entry state
//
// On every edge a fixed-latency entry counts down and drops pending when the
// count is 1. An external completion clears only an entry that is waiting for
// one. A load on the same edge overrides both.
module sb_entry
    import hazard_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             load_ext_i,
    input  logic [LAT_W-1:0] load_cnt_i,
    input  logic             ext_clr_i,
    output sb_entry_t        entry_o
);

    sb_entry_t entry_q, entry_d;

    always_comb begin
        entry_d = entry_q;

        if (entry_q.pending && !entry_q.ext) begin
            if (entry_q.cnt <= LAT_W'(1)) begin
                entry_d.pending = 1'b0;
                entry_d.cnt     = '0;
            end else begin
                entry_d.cnt = entry_q.cnt - LAT_W'(1);
            end
        end

        if (ext_clr_i && entry_q.ext) begin
            entry_d.pending = 1'b0;
            entry_d.ext     = 1'b0;
            entry_d.cnt     = '0;
        end

        if (load_i) begin
            entry_d.pending = 1'b1;
            entry_d.ext     = load_ext_i;
            entry_d.cnt     = load_ext_i ? '0 : load_cnt_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order issue scoreboard for RAW and WAW hazards.
//
// Parameters:
//   NUM_REGS - architectural register count; should be a power of two
//   MAX_LAT  - largest fixed result latency, in cycles
//   EXT_EN   - allow id_lat == 0 to mean unknown latency, cleared by ext_done
//
// Ports:
//   clk    - sole clock
//   rstn   - asynchronous active-low reset; all entries are discarded
//   sb_if  - slave side of hazard_scoreboard_if (ID fields, flush,
//            ext_done, id_stall, id_issue, busy_vec)
//
// id_stall and id_issue are combinational from the ID fields and the
// registered entries. busy_vec comes straight from the registered pending
// bits. Register 0 has no entry and is never busy.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned MAX_LAT  = MAX_LAT_DEF,
    parameter bit          EXT_EN   = 1'b1
) (
    input logic                clk,
    input logic                rstn,
    hazard_scoreboard_if.slave sb_if
);

    localparam int unsigned IdxW = $clog2(NUM_REGS);

    sb_entry_t           entries [NUM_REGS];
    logic [NUM_REGS-1:0] pending_vec;
    logic [NUM_REGS-1:0] ext_vec;

    logic [LAT_W-1:0]    id_lat_w;
    logic [LAT_W-1:0]    rd_cnt;
    logic                raw_hz;
    logic                waw_hz;
    logic                live;
    logic                issue;
    logic                load_ext;
    logic [LAT_W-1:0]    load_cnt;

    assign entries[0] = '0;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_vec
        assign pending_vec[i] = entries[i].pending;
        assign ext_vec[i]     = entries[i].ext;
    end

    assign id_lat_w = LAT_W'(sb_if.id_lat);
    assign rd_cnt   = entries[sb_if.id_rd].cnt;

    // pending_vec[0] is always 0, so index 0 can never raise a hazard.
    always_comb begin
        raw_hz = (sb_if.id_rs1_used && pending_vec[sb_if.id_rs1]) ||
                 (sb_if.id_rs2_used && pending_vec[sb_if.id_rs2]);

        // A later writer may only issue if its result lands strictly after the
        // outstanding one. With an unknown latency on either side, it waits.
        waw_hz = sb_if.id_regwrite && (sb_if.id_rd != '0) && pending_vec[sb_if.id_rd] &&
                 ((sb_if.id_lat == '0) || ext_vec[sb_if.id_rd] || (id_lat_w < rd_cnt));
    end

    assign live  = sb_if.id_valid && !sb_if.flush;
    assign issue = live && !(raw_hz || waw_hz);

    assign sb_if.id_stall = live && (raw_hz || waw_hz);
    assign sb_if.id_issue = issue;
    assign sb_if.busy_vec = pending_vec;

    // Without external completion an unknown latency is treated as the worst case.
    assign load_ext = EXT_EN && (sb_if.id_lat == '0);
    assign load_cnt = (sb_if.id_lat == '0) ? LAT_W'(MAX_LAT) : id_lat_w;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
        logic load;
        logic ext_clr;

        assign load    = issue && sb_if.id_regwrite && (sb_if.id_rd == IdxW'(i));
        assign ext_clr = sb_if.ext_done_valid && (sb_if.ext_done_rd == IdxW'(i));

        sb_entry u_entry (
            .clk_i      (clk),
            .rst_ni     (rstn),
            .load_i     (load),
            .load_ext_i (load_ext),
            .load_cnt_i (load_cnt),
            .ext_clr_i  (ext_clr),
            .entry_o    (entries[i])
        );
    end

endmodule
